// File: rtl/ram_stream_ctrl.sv
// Streaming byte FIFO in front of a single-port RAM: writes the input stream to
// sequential addresses, reads it back in order and buffers read returns for the output stream.
module ram_stream_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int OB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic [ADDR_W-1:0] ram_Addr,
  output logic              ram_CS,
  output logic              ram_WRITE,
  output logic              ram_READ,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int OB_AW = $clog2(OB_DEPTH);
  localparam int OB_CW = $clog2(OB_DEPTH + 1);
  localparam int IF_CW = $clog2(RD_LAT + 2);
  localparam int CR_W  = ((OB_CW > IF_CW) ? OB_CW : IF_CW) + 1;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CR_W-1:0]   CR_MAX   = CR_W'(OB_DEPTH);
  localparam logic [OB_AW-1:0]  OB_LAST  = OB_AW'(OB_DEPTH - 1);
  localparam logic [OB_AW-1:0]  OB_PONE  = OB_AW'(1);
  localparam logic [OB_CW-1:0]  OCC_ONE  = OB_CW'(1);
  localparam logic [OB_CW-1:0]  OCC_ZERO = OB_CW'(0);
  localparam logic [IF_CW-1:0]  IF_ONE   = IF_CW'(1);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   ram_cnt_r;
  logic [ADDR_W:0]   count_r;
  logic [IF_CW-1:0]  inflight_r;
  logic [RD_LAT:0]   rd_pipe_r;
  logic              prefer_wr_r;
  logic [DATA_W-1:0] ob_mem_r [OB_DEPTH];
  logic [OB_AW-1:0]  ob_wr_r;
  logic [OB_AW-1:0]  ob_rd_r;
  logic [OB_CW-1:0]  ob_occ_r;
  logic [DATA_W-1:0] ram_dataIn_r;
  logic [ADDR_W-1:0] ram_Addr_r;
  logic              ram_WRITE_r;
  logic              ram_READ_r;

  logic [CR_W-1:0] credit_s;
  logic            rd_req_s;
  logic            wr_req_s;
  logic            rd_gnt_s;
  logic            wr_gnt_s;
  logic            cap_s;
  logic            pop_s;

  assign credit_s = CR_W'(ob_occ_r) + CR_W'(inflight_r);
  assign cap_s    = rd_pipe_r[RD_LAT];
  assign pop_s    = (ob_occ_r != OCC_ZERO) && out_ready;

  // Arbitration of the single RAM port; ties alternate via the round-robin flag
  always_comb begin
    rd_req_s = (ram_cnt_r != CNT_ZERO) && (credit_s < CR_MAX);
    wr_req_s = in_valid && (ram_cnt_r != CNT_FULL);
    rd_gnt_s = 1'b0;
    wr_gnt_s = 1'b0;
    if (rd_req_s && wr_req_s) begin
      if (prefer_wr_r) begin
        wr_gnt_s = 1'b1;
      end else begin
        rd_gnt_s = 1'b1;
      end
    end else if (rd_req_s) begin
      rd_gnt_s = 1'b1;
    end else if (wr_req_s) begin
      wr_gnt_s = 1'b1;
    end else begin
      rd_gnt_s = 1'b0;
      wr_gnt_s = 1'b0;
    end
  end

  // Pointers, occupancy counters, read-return pipeline and round-robin flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      ram_cnt_r   <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      inflight_r  <= {IF_CW{1'b0}};
      rd_pipe_r   <= {(RD_LAT + 1){1'b0}};
      prefer_wr_r <= 1'b1;
      ob_wr_r     <= {OB_AW{1'b0}};
      ob_rd_r     <= {OB_AW{1'b0}};
      ob_occ_r    <= OCC_ZERO;
    end else begin
      // The pipeline only tracks outstanding reads, so a reset drops late returns
      rd_pipe_r <= {rd_pipe_r[RD_LAT-1:0], rd_gnt_s};
      if (wr_gnt_s) begin
        wr_ptr_r    <= wr_ptr_r + PTR_ONE;
        prefer_wr_r <= 1'b0;
      end else if (rd_gnt_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        prefer_wr_r <= 1'b1;
      end else begin
        prefer_wr_r <= prefer_wr_r;
      end
      case ({wr_gnt_s, rd_gnt_s})
        2'b10:   ram_cnt_r <= ram_cnt_r + CNT_ONE;
        2'b01:   ram_cnt_r <= ram_cnt_r - CNT_ONE;
        default: ram_cnt_r <= ram_cnt_r;
      endcase
      case ({wr_gnt_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      case ({rd_gnt_s, cap_s})
        2'b10:   inflight_r <= inflight_r + IF_ONE;
        2'b01:   inflight_r <= inflight_r - IF_ONE;
        default: inflight_r <= inflight_r;
      endcase
      case ({cap_s, pop_s})
        2'b10:   ob_occ_r <= ob_occ_r + OCC_ONE;
        2'b01:   ob_occ_r <= ob_occ_r - OCC_ONE;
        default: ob_occ_r <= ob_occ_r;
      endcase
      if (cap_s) begin
        ob_wr_r <= (ob_wr_r == OB_LAST) ? {OB_AW{1'b0}} : ob_wr_r + OB_PONE;
      end
      if (pop_s) begin
        ob_rd_r <= (ob_rd_r == OB_LAST) ? {OB_AW{1'b0}} : ob_rd_r + OB_PONE;
      end
    end
  end

  // Output buffer storage; contents are only meaningful under ob_occ_r
  always_ff @(posedge clk) begin
    if (cap_s && !rst) begin
      ob_mem_r[ob_wr_r] <= ram_dataOut;
    end
  end

  // Registered RAM port; address and data hold their last values when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_dataIn_r <= {DATA_W{1'b0}};
      ram_Addr_r   <= {ADDR_W{1'b0}};
      ram_WRITE_r  <= 1'b0;
      ram_READ_r   <= 1'b0;
    end else begin
      ram_WRITE_r <= wr_gnt_s;
      ram_READ_r  <= rd_gnt_s;
      if (wr_gnt_s) begin
        ram_Addr_r   <= wr_ptr_r;
        ram_dataIn_r <= in_data;
      end else if (rd_gnt_s) begin
        ram_Addr_r <= rd_ptr_r;
      end
    end
  end

  assign in_ready   = !rst && (ram_cnt_r != CNT_FULL) && !rd_gnt_s;
  assign out_valid  = (ob_occ_r != OCC_ZERO);
  assign out_data   = ob_mem_r[ob_rd_r];
  assign count      = count_r;
  assign full       = (ram_cnt_r == CNT_FULL);
  assign empty      = (count_r == CNT_ZERO);
  assign ram_dataIn = ram_dataIn_r;
  assign ram_Addr   = ram_Addr_r;
  assign ram_WRITE  = ram_WRITE_r;
  assign ram_READ   = ram_READ_r;
  assign ram_CS     = ram_WRITE_r | ram_READ_r;

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Bench for ram_stream_ctrl: a 1024x8 RAM model, a byte-order scoreboard with
// address/occupancy bookkeeping checked every cycle, and directed scenarios with literal expectations.
module tb_ram_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] count;
  logic        full;
  logic        empty;
  logic [7:0]  ram_dataIn;
  logic [9:0]  ram_Addr;
  logic        ram_CS;
  logic        ram_WRITE;
  logic        ram_READ;
  logic [7:0]  ram_dataOut = 8'h00;

  ram_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .ram_dataIn(ram_dataIn), .ram_Addr(ram_Addr), .ram_CS(ram_CS),
    .ram_WRITE(ram_WRITE), .ram_READ(ram_READ), .ram_dataOut(ram_dataOut)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one cycle from sampling READ to valid dataOut
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (ram_CS && ram_WRITE) mem[ram_Addr] <= ram_dataIn;
    if (ram_CS && ram_READ)  ram_dataOut <= mem[ram_Addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard state
  logic       mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] got_q[$];
  int         cnt_m = 0;
  int         wr_iss = 0;
  int         rd_iss = 0;
  int         pops = 0;
  logic       stall_p = 1'b0;
  logic [7:0] stall_d = 8'h00;
  logic [9:0] last_wa = 10'h000;
  logic [9:0] last_ra = 10'h000;
  logic       wr_wrap = 1'b0;
  logic       rd_wrap = 1'b0;

  // Per-cycle check of the registered outputs, then bookkeeping of the upcoming handshakes
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_excl", 32'(ram_WRITE & ram_READ), 32'd0);
      chk("cs_decode", 32'(ram_CS), 32'(ram_WRITE | ram_READ));
      if (ram_WRITE) begin
        if (wr_q.size() == 0) chk("spurious_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", 32'(ram_Addr), 32'(wr_iss % 1024));
          chk("wr_data", 32'(ram_dataIn), 32'(wr_q.pop_front()));
        end
        if (ram_Addr == 10'h000 && last_wa == 10'h3FF) wr_wrap = 1'b1;
        last_wa = ram_Addr;
        wr_iss++;
      end
      if (ram_READ) begin
        chk("rd_addr", 32'(ram_Addr), 32'(rd_iss % 1024));
        if (ram_Addr == 10'h000 && last_ra == 10'h3FF) rd_wrap = 1'b1;
        last_ra = ram_Addr;
        rd_iss++;
      end
      chk("count", 32'(count), 32'(cnt_m));
      chk("empty", 32'(empty), 32'(cnt_m == 0));
      chk("full", 32'(full), 32'((wr_iss - rd_iss) == 1024));
      chk("buf_credit", 32'((rd_iss - pops) <= 4), 32'd1);
      if (full) chk("in_ready_full", 32'(in_ready), 32'd0);
      if (stall_p) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_d));
      end
      if (rst) begin
        chk("in_ready_rst", 32'(in_ready), 32'd0);
        exp_q.delete(); wr_q.delete();
        cnt_m = 0; wr_iss = 0; rd_iss = 0; pops = 0;
        stall_p = 1'b0; last_wa = 10'h000; last_ra = 10'h000;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
          else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          got_q.push_back(out_data);
          pops++;
          cnt_m--;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
          wr_q.push_back(in_data);
          cnt_m++;
        end
        stall_p = out_valid && !out_ready;
        stall_d = out_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        return;
      end
    end
    chk("push_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (empty && !out_valid) begin
        step();
        return;
      end
    end
    chk("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  logic done;
  logic [7:0] exp1 [5];
  int c0;
  int p0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    exp1[0] = 8'h01; exp1[1] = 8'h12; exp1[2] = 8'h13; exp1[3] = 8'h16; exp1[4] = 8'h02;
    repeat (2) step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ram_cs", 32'({ram_CS, ram_WRITE, ram_READ}), 32'd0);
    chk("rst_ram_addr", 32'(ram_Addr), 32'd0);
    chk("rst_ram_din", 32'(ram_dataIn), 32'd0);
    step();

    // Five bytes buffered with the consumer stalled, then drained in order
    for (int i = 0; i < 5; i++) push(exp1[i]);
    in_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("t1_count", 32'(count), 32'd5);
    chk("t1_head", 32'(out_data), 32'h01);
    step();
    got_q.delete();
    out_ready = 1'b1;
    wait_empty();
    chk("t1_len", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t1_byte", 32'(got_q[i]), 32'(exp1[i]));

    // Minimum latency: written at edge N, visible after edge N+3
    out_ready = 1'b0;
    push(8'hA5);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'hA5);
    step();
    out_ready = 1'b1;
    wait_empty();

    // Fill: RAM full plus a full output buffer, extra byte held off
    out_ready = 1'b0;
    for (int i = 0; i < 1028; i++) push(8'(i));
    repeat (5) step();
    @(negedge clk);
    chk("fill_count", 32'(count), 32'd1028);
    chk("fill_full", 32'(full), 32'd1);
    step();
    in_valid = 1'b1;
    in_data  = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fill_hold", 32'(in_ready), 32'd0);
    end
    step();
    out_ready = 1'b1;
    push(8'h04);
    in_valid = 1'b0;

    // Wrap: drain part, refill across address 0x3FF->0x000, drain all
    p0 = pops;
    for (int t = 0; t < 3000 && (pops - p0) < 610; t++) @(negedge clk);
    chk("wrap_drained", 32'((pops - p0) >= 610), 32'd1);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 600; i++) push(8'(i * 7 + 3));
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_empty();
    chk("wrap_wr_ptr", 32'(wr_wrap), 32'd1);
    chk("wrap_rd_ptr", 32'(rd_wrap), 32'd1);
    chk("wrap_count", 32'(count), 32'd0);

    // Sustained traffic: grants alternate, one byte per two cycles
    c0 = cyc;
    for (int i = 0; i < 100; i++) push(8'(8'hC0 ^ i));
    chk("throughput_span", 32'(cyc - c0), 32'd199);
    in_valid = 1'b0;
    wait_empty();

    // Random consumer back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) push(8'($urandom_range(0, 255)));
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    // Reset with bytes stored and a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    begin
      int t;
      for (t = 0; t < 20; t++) begin
        @(negedge clk);
        if (ram_READ) break;
      end
      chk("rst_read_seen", 32'(t < 20), 32'd1);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_strobes", 32'({ram_CS, ram_WRITE, ram_READ}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_data_hidden", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
